axis_fifo_stream_master: RTL and testbench
==========================================

# axis_fifo_stream_master

AXI4-Stream master that drains a first-word-fall-through (FWFT) FIFO and presents each word as one stream beat. It sits between an upstream FIFO, which holds data produced by the IP, and the IP's M00_AXIS output port. It adds one registered output stage so that TVALID, TDATA and TLAST are glitch-free register outputs, and it frames fixed-length packets with TLAST.

## Interface
Parameters:
- C_M_AXIS_TDATA_WIDTH, 32: stream and FIFO data width in bits; must be a multiple of 8.
- C_PACKET_LEN, 32: beats per packet; TLAST marks the final beat. Must be ≥ 1.

Ports:
- M_AXIS_ACLK  in  1  single clock; all logic is on its rising edge.
- M_AXIS_ARESETN  in  1  reset, synchronous, active-high (asserted = 1) despite the _N suffix.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  beat data.
- M_AXIS_TKEEP  out  C_M_AXIS_TDATA_WIDTH/8  byte keep; constant all-ones.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TREADY  in  1  downstream ready.
- empty  in  1  FIFO empty flag.
- fifo_data  in  C_M_AXIS_TDATA_WIDTH  FIFO head word; valid whenever empty=0 (FWFT).
- pop_en  out  1  FIFO read strobe; the FIFO advances its head at the rising edge where pop_en=1.

## Operation
- The output register holds at most one beat.
- Define load = !empty && (!M_AXIS_TVALID || M_AXIS_TREADY). This is combinational.
- pop_en = load. It may depend on TREADY, because it goes only to the FIFO.
- On a clock edge with load=1: TDATA <= fifo_data, TVALID <= 1, TLAST <= (beat_cnt == C_PACKET_LEN-1).
- On a clock edge with TVALID && TREADY and load=0: TVALID <= 0. TDATA and TLAST hold their values.
- On a clock edge with TVALID && !TREADY: TVALID, TDATA and TLAST are all frozen (AXIS stability rule).
- beat_cnt has width clog2(C_PACKET_LEN), minimum 1 bit.
  - It increments on each load and wraps to 0 after the beat loaded with TLAST=1.
  - It counts loaded beats, not accepted beats. Each loaded beat is accepted exactly once, so the framing is identical.
- TVALID never depends combinationally on TREADY.
- Once TVALID is asserted, it stays asserted until the beat is accepted.
- TKEEP is tied to all-ones. The block has no partial beats.

## Timing
- Reset (M_AXIS_ARESETN=1 at a rising edge) sets:
  - TVALID=0, TDATA=0, TLAST=0, beat_cnt=0.
  - pop_en is 0 while reset is asserted.
- Reset mid-stream: a beat held in the output register is discarded. It was already popped, so it is lost. Packet framing restarts at beat 0.
- Latency: if empty falls at edge k, then pop_en=1 during cycle k→k+1, and TVALID=1 with the head word after edge k+1. This is one cycle.
- Throughput: with TREADY held high and the FIFO non-empty, the block delivers one beat per cycle with no bubbles.
- Simultaneous accept and load in one edge: the new word replaces the old one and TVALID stays 1.
- FIFO empty while the output register is full: TVALID stays 1 and the held beat waits. When that beat is accepted, TVALID drops to 0.
- Output register full and TREADY=0: pop_en=0, regardless of the FIFO state.

## Structure
- Shared package axis_pkg:
  - KEEP_W = C_M_AXIS_TDATA_WIDTH/8.
  - a clog2 function for the beat counter width.
- No sub-module: a single always block for the output register plus the counter is sufficient.
- The FIFO is a separate peer block and is not part of this design.

## Test plan
- Reset, then FIFO pre-filled with 1..32 and TREADY=0 → TVALID=1 and TDATA=1 one cycle after empty falls, held for 10+ cycles. pop_en pulses exactly once. TKEEP=4'hF.
- Single-cycle TREADY pulse → exactly one beat (value 1) accepted. Next edge shows TDATA=2 with TVALID still 1. A second pulse 7 cycles later → TDATA advances to 3.
- Continuous TREADY=1 → values 3..32 accepted on consecutive cycles. TLAST=1 only on the beat with TDATA=32. TVALID falls after that beat, and pop_en stays 0 while empty=1.
- C_PACKET_LEN=4, 12 words streamed → TLAST on words 4, 8 and 12. The counter wraps correctly.
- FIFO goes empty and non-empty intermittently with TREADY=1 → no duplicated or skipped words. TVALID=0 only when no data is held.
- Reset asserted while TVALID=1 and TREADY=0 → next edge gives TVALID=0 and TDATA=0. After reset releases, the first beat loaded has beat_cnt=0.

Source files
------------

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axis_pkg
// Description : Shared definitions for the AXI4-Stream FIFO master slice:
//               default stream width, byte-keep width helper and a clog2
//               helper that never returns less than one bit.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  // Default stream/FIFO data width in bits (multiple of 8).
  localparam int DEFAULT_TDATA_WIDTH = 32;

  // Default number of beats per packet.
  localparam int DEFAULT_PACKET_LEN = 32;

  // Byte-keep width for a given data width: KEEP_W = width / 8.
  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

  // Bits needed to count 0..value-1, with a floor of one bit so that a
  // single-beat packet still has a legal counter vector.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_fifo_stream_master_if.sv
`default_nettype none
// ============================================================================
// Interface   : axis_fifo_stream_master_if
// Description : AXI4-Stream bus bundle (TVALID/TDATA/TKEEP/TLAST/TREADY).
//               The master modport drives the beat, the slave modport drives
//               the ready back-pressure.
// Signals     : tvalid  - beat valid
//               tdata   - beat data, DATA_W bits
//               tkeep   - byte keep, DATA_W/8 bits
//               tlast   - last beat of packet
//               tready  - downstream ready
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_fifo_stream_master_if
  import axis_pkg::*;
#(
  parameter int DATA_W = DEFAULT_TDATA_WIDTH
) ();

  localparam int KEEP_W = keep_width(DATA_W);

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tready;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    output tready
  );

endinterface : axis_fifo_stream_master_if
`default_nettype wire

// File: rtl/axis_fifo_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_stream_master
// Description : Drains a first-word-fall-through FIFO onto an AXI4-Stream
//               master port through a single registered output stage, and
//               frames fixed-length packets of C_PACKET_LEN beats with TLAST.
// Ports       : M_AXIS_ACLK     - clock, rising edge
//               M_AXIS_ARESETN  - synchronous reset, active HIGH despite name
//               m_axis          - stream bus (master modport)
//               empty           - FIFO empty flag
//               fifo_data       - FIFO head word, valid while empty = 0
//               pop_en          - FIFO read strobe (advances head at edge)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_stream_master
  import axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
  parameter int C_PACKET_LEN         = DEFAULT_PACKET_LEN
) (
  input  wire logic                            M_AXIS_ACLK,
  input  wire logic                            M_AXIS_ARESETN,
  axis_fifo_stream_master_if.master            m_axis,
  input  wire logic                            empty,
  input  wire logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_data,
  output      logic                            pop_en
);

  localparam int                CNT_W    = clog2(C_PACKET_LEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(C_PACKET_LEN - 1);

  logic                            tvalid_q;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                            tlast_q;
  logic [CNT_W-1:0]                beat_cnt;
  logic                            load;
  logic                            beat_is_last;

  // The output register can take a new word when it is empty or when its
  // current beat leaves in this same cycle. TREADY only feeds pop_en and the
  // register enable, never TVALID itself, so TVALID stays a pure flop output.
  assign load         = !empty && (!tvalid_q || m_axis.tready);
  assign beat_is_last = (beat_cnt == LAST_CNT);

  // The FIFO must not advance while reset holds the register in its cleared
  // state, otherwise a word would be popped and never presented.
  assign pop_en = load && !M_AXIS_ARESETN;

  // Output register and packet counter. The counter tracks loaded beats;
  // since every loaded beat is accepted exactly once the framing matches
  // the accepted stream.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESETN) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      beat_cnt <= '0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tdata_q  <= fifo_data;
      tlast_q  <= beat_is_last;
      beat_cnt <= beat_is_last ? '0 : beat_cnt + 1'b1;
    end else if (tvalid_q && m_axis.tready) begin
      // Accepted with nothing to replace it: drop valid, keep data/last.
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tkeep  = '1;

endmodule : axis_fifo_stream_master
`default_nettype wire

// File: tb/tb_axis_fifo_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_fifo_stream_master
// Description : Self-checking bench for axis_fifo_stream_master. Two
//               instances (packet lengths 32 and 4) share one FIFO model and
//               one TREADY. A scoreboard holds words popped from the FIFO
//               but not yet accepted downstream; a monitor compares the
//               presented beat against it and derives TLAST from the count
//               of accepted beats since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_stream_master;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  logic        empty;
  logic [W-1:0] fifo_data;
  logic        pop32;
  logic        pop4;

  axis_fifo_stream_master_if #(.DATA_W(W)) ax32 ();
  axis_fifo_stream_master_if #(.DATA_W(W)) ax4 ();

  axis_fifo_stream_master #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .C_PACKET_LEN         (32)
  ) dut32 (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst),
    .m_axis         (ax32),
    .empty          (empty),
    .fifo_data      (fifo_data),
    .pop_en         (pop32)
  );

  axis_fifo_stream_master #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .C_PACKET_LEN         (4)
  ) dut4 (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst),
    .m_axis         (ax4),
    .empty          (empty),
    .fifo_data      (fifo_data),
    .pop_en         (pop4)
  );

  logic tready;
  assign ax32.tready = tready;
  assign ax4.tready  = tready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  logic [W-1:0] fifo_q[$];   // FIFO contents
  logic [W-1:0] sb[$];       // popped, not yet accepted
  int           total = 0;
  int           bad   = 0;
  int           acc_cnt = 0; // accepted beats since reset
  int           pops_seen = 0;
  bit           pop_req = 0;
  bit           started = 0;
  logic [W-1:0] last_data = '0;
  logic         last_tlast32 = 1'b0;
  logic         last_tlast4  = 1'b0;
  logic [W-1:0] next_word = 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_pop;
    if (started) begin
      exp_valid = (sb.size() != 0);
      check("tvalid32", ax32.tvalid, exp_valid);
      check("tvalid4",  ax4.tvalid,  exp_valid);
      check("tkeep32",  ax32.tkeep,  4'hF);
      check("tkeep4",   ax4.tkeep,   4'hF);
      if (exp_valid) begin
        check("tdata32", ax32.tdata, sb[0]);
        check("tdata4",  ax4.tdata,  sb[0]);
        check("tlast32", ax32.tlast, ((acc_cnt % 32) == 31));
        check("tlast4",  ax4.tlast,  ((acc_cnt % 4) == 3));
      end else begin
        check("hold_tdata32", ax32.tdata, last_data);
        check("hold_tdata4",  ax4.tdata,  last_data);
        check("hold_tlast32", ax32.tlast, last_tlast32);
        check("hold_tlast4",  ax4.tlast,  last_tlast4);
      end
      exp_pop = !rst && (fifo_q.size() != 0) && (!exp_valid || tready);
      check("pop_en32", pop32, exp_pop);
      check("pop_en4",  pop4,  exp_pop);
      if (pop32) pops_seen++;

      // Predict the effect of the coming rising edge.
      if (rst) begin
        sb.delete();
        acc_cnt      = 0;
        last_data    = '0;
        last_tlast32 = 1'b0;
        last_tlast4  = 1'b0;
      end else begin
        if (exp_valid && tready) begin
          last_tlast32 = ((acc_cnt % 32) == 31);
          last_tlast4  = ((acc_cnt % 4) == 3);
          last_data    = sb.pop_front();
          acc_cnt++;
        end
        if (exp_pop) begin
          sb.push_back(fifo_q[0]);
          pop_req = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic refresh();
    empty     = (fifo_q.size() == 0);
    fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_req) begin
      void'(fifo_q.pop_front());
      pop_req = 0;
    end
    refresh();
  endtask

  task automatic push_word();
    fifo_q.push_back(next_word);
    next_word = next_word + 1;
    refresh();
  endtask

  task automatic drain(input int budget);
    int n;
    rst    = 1'b0;
    tready = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (fifo_q.size() != 0 || sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: fifo=%0d held=%0d after %0d cycles", fifo_q.size(), sb.size(), n);
    end
    repeat (2) tick();
  endtask

  initial begin
    rst       = 1'b1;
    tready    = 1'b0;
    empty     = 1'b1;
    fifo_data = '0;
    tick();
    started = 1;
    repeat (2) tick();

    // Pre-filled FIFO 1..32, no ready: one pop, beat 1 held.
    rst = 1'b0;
    pops_seen = 0;
    for (int i = 0; i < 32; i++) push_word();
    repeat (12) tick();
    check("pop_once", pops_seen, 1);

    // Single-cycle ready pulses 7 cycles apart.
    tready = 1'b1; tick();
    tready = 1'b0; repeat (7) tick();
    tready = 1'b1; tick();
    tready = 1'b0; repeat (2) tick();

    // Continuous ready drains 3..32; TLAST on 32 (len 32) and every 4th.
    drain(80);
    repeat (3) tick();

    // Twelve-word burst.
    for (int i = 0; i < 12; i++) push_word();
    drain(40);

    // Intermittent FIFO with ready held.
    tready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0) push_word();
      tick();
    end
    drain(40);

    // Reset while a beat is held and stalled.
    for (int i = 0; i < 3; i++) push_word();
    tready = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (2) tick();
    drain(40);

    // Random ready, random arrivals, occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0 && fifo_q.size() < 6) push_word();
      tready = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 79) == 0);
      tick();
    end
    drain(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axis_fifo_stream_master
`default_nettype wire
